// File: rtl/power_gating_sequencer.sv
// Power-gating sequencer for the alu/mem/io domains: idle tracking,
// wake-first round-robin arbitration and one switch transition at a time.
module power_gating_sequencer #(
    parameter int NUM_DOMAINS   = 3,
    parameter int IDLE_THRESH   = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int ACK_TIMEOUT   = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_DOMAINS-1:0] idle,
    input  logic [NUM_DOMAINS-1:0] wake_req,
    input  logic [NUM_DOMAINS-1:0] pwr_ack,
    output logic [NUM_DOMAINS-1:0] iso_en,
    output logic [NUM_DOMAINS-1:0] pwr_sw_en,
    output logic [NUM_DOMAINS-1:0] domain_gated,
    output logic [NUM_DOMAINS-1:0] fault,
    output logic                   busy
);
    localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    typedef enum logic [2:0] {
        IDLE, ISO_ON, SW_OFF, SW_ON, SETTLE, ISO_OFF
    } state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          act_q, act_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [7:0]             cnt_q [NUM_DOMAINS];
    logic [7:0]             cnt_d [NUM_DOMAINS];
    logic [7:0]             wait_q, wait_d;
    logic [7:0]             settle_q, settle_d;
    logic [NUM_DOMAINS-1:0] iso_d, sw_d, gated_d, fault_d;
    logic                   busy_d;
    logic [NUM_DOMAINS-1:0] gate_req, wake_rq, req;
    logic                   grant_vld;
    logic [IW-1:0]          grant_idx;

    // Wake requests beat gate requests; the lowest offset after ptr wins.
    always_comb begin
        for (int d = 0; d < NUM_DOMAINS; d++) begin
            gate_req[d] = (cnt_q[d] == 8'(IDLE_THRESH))
                        && !domain_gated[d] && !fault[d];
        end
        wake_rq   = wake_req & domain_gated & ~fault;
        req       = (|wake_rq) ? wake_rq : gate_req;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = NUM_DOMAINS; k >= 1; k--) begin
            if (req[IW'((int'(ptr_q) + k) % NUM_DOMAINS)]) begin
                grant_vld = 1'b1;
                grant_idx = IW'((int'(ptr_q) + k) % NUM_DOMAINS);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        act_d    = act_q;
        ptr_d    = ptr_q;
        wait_d   = wait_q;
        settle_d = settle_q;
        iso_d    = iso_en;
        sw_d     = pwr_sw_en;
        gated_d  = domain_gated;
        fault_d  = fault;
        for (int d = 0; d < NUM_DOMAINS; d++) begin
            cnt_d[d] = cnt_q[d];
            if (!idle[d] || domain_gated[d]) begin
                cnt_d[d] = '0;
            end else if (!fault[d] && !(busy && act_q == IW'(d))
                         && cnt_q[d] != 8'(IDLE_THRESH)) begin
                cnt_d[d] = cnt_q[d] + 8'd1;
            end
        end
        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    act_d  = grant_idx;
                    ptr_d  = grant_idx;
                    wait_d = '0;
                    if (|wake_rq) begin
                        sw_d[grant_idx] = 1'b1;
                        state_d         = SW_ON;
                    end else begin
                        iso_d[grant_idx] = 1'b1;
                        state_d          = ISO_ON;
                    end
                end
            end
            ISO_ON: begin
                sw_d[act_q] = 1'b0;
                wait_d      = '0;
                state_d     = SW_OFF;
            end
            SW_OFF: begin
                if (!pwr_ack[act_q]) begin
                    gated_d[act_q] = 1'b1;
                    state_d        = IDLE;
                end else if (wait_q == 8'(ACK_TIMEOUT - 1)) begin
                    fault_d[act_q] = 1'b1;
                    state_d        = IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            SW_ON: begin
                if (pwr_ack[act_q]) begin
                    settle_d = '0;
                    state_d  = SETTLE;
                end else if (wait_q == 8'(ACK_TIMEOUT - 1)) begin
                    fault_d[act_q] = 1'b1;
                    state_d        = IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            SETTLE: begin
                if (settle_q == 8'(SETTLE_CYCLES - 1)) begin
                    iso_d[act_q]   = 1'b0;
                    gated_d[act_q] = 1'b0;
                    state_d        = ISO_OFF;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            ISO_OFF: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            act_q        <= '0;
            ptr_q        <= '0;
            wait_q       <= '0;
            settle_q     <= '0;
            iso_en       <= '0;
            pwr_sw_en    <= '1;
            domain_gated <= '0;
            fault        <= '0;
            busy         <= 1'b0;
            for (int d = 0; d < NUM_DOMAINS; d++) cnt_q[d] <= '0;
        end else begin
            state_q      <= state_d;
            act_q        <= act_d;
            ptr_q        <= ptr_d;
            wait_q       <= wait_d;
            settle_q     <= settle_d;
            iso_en       <= iso_d;
            pwr_sw_en    <= sw_d;
            domain_gated <= gated_d;
            fault        <= fault_d;
            busy         <= busy_d;
            for (int d = 0; d < NUM_DOMAINS; d++) cnt_q[d] <= cnt_d[d];
        end
    end
endmodule

// File: tb/tb_power_gating_sequencer.sv
// Bench for power_gating_sequencer: directed test-plan steps then random
// idle/wake traffic, all checked cycle by cycle against a job-level model.
module tb_power_gating_sequencer;
    localparam int N  = 3;
    localparam int IT = 4;
    localparam int SC = 2;
    localparam int AT = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] idle = '0;
    logic [N-1:0] wake_req = '0;
    logic [N-1:0] pwr_ack;
    logic [N-1:0] iso_en, pwr_sw_en, domain_gated, fault;
    logic         busy;
    logic [N-1:0] p1, p2;
    logic         stuck1 = 1'b0;
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    // Switch model: rail follows the enable two edges later.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p1 <= '1;
            p2 <= '1;
        end else begin
            p1 <= pwr_sw_en;
            p2 <= p1;
        end
    end
    assign pwr_ack = {p2[2], p2[1] | stuck1, p2[0]};

    power_gating_sequencer #(
        .NUM_DOMAINS(N), .IDLE_THRESH(IT),
        .SETTLE_CYCLES(SC), .ACK_TIMEOUT(AT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .idle(idle),
        .wake_req(wake_req), .pwr_ack(pwr_ack),
        .iso_en(iso_en), .pwr_sw_en(pwr_sw_en),
        .domain_gated(domain_gated), .fault(fault), .busy(busy)
    );

    logic [N-1:0] m_iso, m_sw, m_gated, m_fault;
    logic         m_busy;
    int           streak [N];
    int           last;
    bit           job_on, job_wake;
    int           job_dom, job_ph, job_wait, job_settle;
    logic [N-1:0] pv_iso, pv_sw;
    logic         pv_busy;
    int           grants [$];

    task automatic chk(string tag, logic [N-1:0] got, logic [N-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_iso = '0; m_sw = '1; m_gated = '0; m_fault = '0; m_busy = 1'b0;
        for (int d = 0; d < N; d++) streak[d] = 0;
        last = 0; job_on = 0; job_wake = 0;
        job_dom = 0; job_ph = 0; job_wait = 0; job_settle = 0;
        pv_iso = '0; pv_sw = '1; pv_busy = 1'b0;
    endtask

    function automatic int rr(logic [N-1:0] r, int from);
        for (int k = 1; k <= N; k++)
            if (r[(from + k) % N]) return (from + k) % N;
        return -1;
    endfunction

    task automatic finish_job();
        job_on = 0;
        m_busy = 1'b0;
    endtask

    task automatic wait_or_fault(int d);
        job_wait++;
        if (job_wait == AT) begin
            m_fault[d] = 1'b1;
            finish_job();
        end
    endtask

    // Predicts the state after the coming rising edge.
    task automatic model_step();
        int ns [N];
        logic [N-1:0] wk, gt;
        int pick, d;
        for (int i = 0; i < N; i++) begin
            if (!idle[i] || m_gated[i]) ns[i] = 0;
            else if (m_fault[i] || (job_on && job_dom == i)) ns[i] = streak[i];
            else ns[i] = (streak[i] + 1 > IT) ? IT : streak[i] + 1;
        end
        if (!job_on) begin
            wk = wake_req & m_gated & ~m_fault;
            gt = '0;
            for (int i = 0; i < N; i++)
                gt[i] = (streak[i] == IT) && !m_gated[i] && !m_fault[i];
            pick = (wk != '0) ? rr(wk, last) : rr(gt, last);
            if (pick >= 0) begin
                job_on = 1; job_dom = pick; job_wake = (wk != '0);
                job_ph = 0; job_wait = 0; last = pick; m_busy = 1'b1;
                if (job_wake) m_sw[pick] = 1'b1;
                else m_iso[pick] = 1'b1;
            end
        end else begin
            d = job_dom;
            if (!job_wake) begin
                if (job_ph == 0) begin
                    m_sw[d] = 1'b0; job_ph = 1; job_wait = 0;
                end else if (!pwr_ack[d]) begin
                    m_gated[d] = 1'b1; finish_job();
                end else wait_or_fault(d);
            end else begin
                if (job_ph == 0) begin
                    if (pwr_ack[d]) begin job_ph = 1; job_settle = 0; end
                    else wait_or_fault(d);
                end else if (job_ph == 1) begin
                    job_settle++;
                    if (job_settle == SC) begin
                        m_iso[d] = 1'b0; m_gated[d] = 1'b0; job_ph = 2;
                    end
                end else finish_job();
            end
        end
        for (int i = 0; i < N; i++) streak[i] = ns[i];
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        chk("iso_en", iso_en, m_iso);
        chk("pwr_sw_en", pwr_sw_en, m_sw);
        chk("domain_gated", domain_gated, m_gated);
        chk("fault", fault, m_fault);
        chk("busy", {2'b00, busy}, {2'b00, m_busy});
        if (busy && !pv_busy)
            for (int d = 0; d < N; d++)
                if ((iso_en[d] ^ pv_iso[d]) | (pwr_sw_en[d] ^ pv_sw[d]))
                    grants.push_back(d);
        pv_iso = iso_en; pv_sw = pwr_sw_en; pv_busy = busy;
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_iso"}, iso_en, 3'b000);
        chk({tag, "_sw"}, pwr_sw_en, 3'b111);
        chk({tag, "_gated"}, domain_gated, 3'b000);
        chk({tag, "_fault"}, fault, 3'b000);
        chk({tag, "_busy"}, {2'b00, busy}, 3'b000);
    endtask

    initial begin
        int fi, fg;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset_n = 1'b1;

        // single gate of domain 0
        idle = 3'b001;
        for (int i = 0; i < 40 && !(domain_gated[0] && !busy); i++) tick();
        chk("gate0_gated", domain_gated, 3'b001);

        // idle glitch on domain 1: 3 high, 1 low, 4 high
        idle[1] = 1'b1; repeat (3) tick();
        idle[1] = 1'b0; tick();
        idle[1] = 1'b1; repeat (4) tick();
        chk("glitch_nogrant", {2'b00, busy}, 3'b000);
        tick();
        chk("glitch_grant", {2'b00, busy}, 3'b001);
        for (int i = 0; i < 40 && !(domain_gated[1] && !busy); i++) tick();
        chk("glitch_gated", domain_gated, 3'b011);

        idle = 3'b000; wake_req = 3'b010;
        for (int i = 0; i < 40 && !(!domain_gated[1] && !busy); i++) tick();
        chk("wake1_done", domain_gated, 3'b001);
        wake_req = '0;

        // wake priority and round-robin
        grants.delete();
        idle = 3'b110; repeat (4) tick();
        wake_req = 3'b001;
        for (int i = 0; i < 80 && !(domain_gated == 3'b110 && !busy); i++) tick();
        wake_req = '0;
        chk("rr_gated", domain_gated, 3'b110);
        chk("rr_count", 3'(grants.size()), 3'd3);
        for (int i = 0; i < 3 && i < grants.size(); i++)
            chk("rr_order", 3'(grants[i]), 3'(i));

        // wake sequence on io
        idle = 3'b000; wake_req = 3'b100; fi = -1; fg = -1;
        for (int i = 0; i < 40 && !(!domain_gated[2] && !busy); i++) begin
            tick();
            if (fi < 0 && !iso_en[2]) fi = i;
            if (fg < 0 && !domain_gated[2]) fg = i;
        end
        wake_req = '0;
        chk("wake2_gated", domain_gated, 3'b010);
        chk("wake2_same_edge", 3'(fi - fg), 3'd0);

        // timeout on domain 1
        wake_req = 3'b010;
        for (int i = 0; i < 40 && !(!domain_gated[1] && !busy); i++) tick();
        wake_req = '0;
        grants.delete();
        stuck1 = 1'b1; idle = 3'b010;
        for (int i = 0; i < 60 && !(fault[1] && !busy); i++) tick();
        chk("to_fault", fault, 3'b010);
        chk("to_iso", iso_en, 3'b010);
        chk("to_sw", pwr_sw_en, 3'b101);
        idle = 3'b011;
        for (int i = 0; i < 40 && !(domain_gated[0] && !busy); i++) tick();
        repeat (20) tick();
        chk("to_other_gated", domain_gated, 3'b001);
        chk("to_grants", 3'(grants.size()), 3'd2);
        if (grants.size() == 2) begin
            chk("to_grant0", 3'(grants[0]), 3'd1);
            chk("to_grant1", 3'(grants[1]), 3'd0);
        end

        // async reset in SETTLE
        stuck1 = 1'b0; idle = 3'b000; wake_req = 3'b001;
        for (int i = 0; i < 20 && !(job_on && job_wake && job_ph == 1); i++)
            tick();
        chk("settle_reached", {2'b00, busy}, 3'b001);
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("async");
        wake_req = '0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // random traffic
        for (int i = 0; i < 1000; i++) begin
            for (int d = 0; d < N; d++) begin
                if ($urandom_range(0, 5) == 0) idle[d] = ~idle[d];
                wake_req[d] = ($urandom_range(0, 11) == 0);
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
